// File: rtl/vga_text_engine.sv
// Text-mode VGA core: raster timing, char+attr cell RAM, font-ROM fetch, 3-stage pixel pipeline, clear engine.
// Optional blinking underline cursor when VGA_CURSOR_EN is defined.
module vga_text_engine #(
    parameter int COLS = 50, ROWS = 37, CHAR_W = 8, CHAR_H = 16, CHAR_BITS = 7, ADDR_W = 11,
    parameter int H_ACTIVE = 400, H_FP = 20, H_SYNC = 64, H_BP = 44,
    parameter int V_ACTIVE = 600, V_FP = 1, V_SYNC = 4, V_BP = 23,
    parameter logic SYNC_POL = 1'b1,
    parameter logic [CHAR_BITS-1:0] CLR_CHAR = 7'h20
) (
    input  logic                                  clk_20_mhz,
    input  logic                                  rst_n,
    input  logic [ADDR_W-1:0]                     address,
    input  logic [CHAR_BITS-1:0]                  char_input,
    input  logic [5:0]                            attr_input,
    input  logic                                  write_enable,
    output logic                                  wr_ready,
    input  logic                                  clr_start,
    output logic                                  clr_busy,
`ifdef VGA_CURSOR_EN
    input  logic [ADDR_W-1:0]                     cursor_addr,
    input  logic                                  cursor_on,
`endif
    output logic [CHAR_BITS+$clog2(CHAR_H)-1:0]   font_addr,
    input  logic [CHAR_W-1:0]                     font_bits,
    output logic                                  red,
    output logic                                  green,
    output logic                                  blue,
    output logic                                  horizontal_sync,
    output logic                                  vertical_sync
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LINE_W  = $clog2(CHAR_H);
    localparam int PIX_W   = $clog2(CHAR_W);
    localparam int CELLS   = COLS * ROWS;
    localparam int WORD_W  = CHAR_BITS + 6;

    // ---------------- S0: raster counters ----------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge clk_20_mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic [31:0]       h_ext, v_ext, col_s0, row_s0;
    logic [ADDR_W-1:0] cell_addr_s0;
    logic [LINE_W-1:0] line_s0;
    logic [PIX_W-1:0]  pix_s0;
    logic              vis_s0, hs_s0, vs_s0, cur_s0;

    assign h_ext        = 32'(h_cnt);
    assign v_ext        = 32'(v_cnt);
    assign col_s0       = h_ext / CHAR_W;
    assign row_s0       = v_ext / CHAR_H;
    assign cell_addr_s0 = ADDR_W'(row_s0 * COLS + col_s0);
    assign line_s0      = LINE_W'(v_ext % CHAR_H);
    assign pix_s0       = PIX_W'(h_ext % CHAR_W);
    // Cells past the text grid (e.g. the partial row below ROWS) stay black.
    assign vis_s0 = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE) && (col_s0 < COLS) && (row_s0 < ROWS);
    assign hs_s0  = (h_ext >= H_ACTIVE + H_FP && h_ext < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vs_s0  = (v_ext >= V_ACTIVE + V_FP && v_ext < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_CURSOR_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk_20_mhz or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (h_cnt == HW'(H_TOTAL - 1) && v_cnt == VW'(V_TOTAL - 1))
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign cur_s0 = cursor_on && frame_cnt[5] && (cell_addr_s0 == cursor_addr)
                    && ((v_ext % CHAR_H) >= CHAR_H - 2);
`else
    assign cur_s0 = 1'b0;
`endif

    // ---------------- clear engine ----------------
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg;

    always_ff @(posedge clk_20_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= (state_reg == CLEAR) ? clr_addr_reg + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_ready   = 1'b0;
        clr_busy   = 1'b0;
        case (state_reg)
            IDLE: begin
                wr_ready = 1'b1;
                if (clr_start)
                    state_next = CLEAR;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_addr_reg == ADDR_W'(CELLS - 1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- cell RAM: one write port (host or clear), one raster read port ----------------
    logic [WORD_W-1:0] cell_ram [0:(2**ADDR_W)-1];
    logic              ram_we, host_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;

    // A clear request in the same cycle takes priority over the host write.
    assign host_we   = wr_ready && write_enable && !clr_start && (32'(address) < CELLS);
    assign ram_we    = clr_busy || host_we;
    assign ram_waddr = clr_busy ? clr_addr_reg : address;
    assign ram_wdata = clr_busy ? {CLR_CHAR, 6'b111_000} : {char_input, attr_input};

    always_ff @(posedge clk_20_mhz) begin
        if (ram_we)
            cell_ram[ram_waddr] <= ram_wdata;
    end

    // ---------------- S1..S3 pixel pipeline ----------------
    logic [WORD_W-1:0] cell_s1;
    logic [LINE_W-1:0] line_s1;
    logic [PIX_W-1:0]  pix_s1, pix_s2;
    logic              vis_s1, vis_s2, cur_s1, cur_s2;
    logic [CHAR_W-1:0] fbits_s2;
    logic [5:0]        attr_s2;
    logic [2:0]        rgb_reg, rgb_next;
    logic [2:0]        hs_pipe, vs_pipe;
    logic              glyph_bit;

    assign font_addr = {cell_s1[WORD_W-1:6], line_s1};
    assign glyph_bit = fbits_s2[PIX_W'(CHAR_W - 1) - pix_s2] | cur_s2;
    assign rgb_next  = !vis_s2 ? 3'b000 : (glyph_bit ? attr_s2[5:3] : attr_s2[2:0]);

    always_ff @(posedge clk_20_mhz or negedge rst_n) begin
        if (!rst_n) begin
            cell_s1  <= '0;
            line_s1  <= '0;
            pix_s1   <= '0;
            vis_s1   <= 1'b0;
            cur_s1   <= 1'b0;
            pix_s2   <= '0;
            vis_s2   <= 1'b0;
            cur_s2   <= 1'b0;
            fbits_s2 <= '0;
            attr_s2  <= '0;
            rgb_reg  <= '0;
            hs_pipe  <= {3{~SYNC_POL}};
            vs_pipe  <= {3{~SYNC_POL}};
        end else begin
            cell_s1  <= cell_ram[cell_addr_s0];
            line_s1  <= line_s0;
            pix_s1   <= pix_s0;
            vis_s1   <= vis_s0;
            cur_s1   <= cur_s0;
            pix_s2   <= pix_s1;
            vis_s2   <= vis_s1;
            cur_s2   <= cur_s1;
            fbits_s2 <= font_bits;
            attr_s2  <= cell_s1[5:0];
            rgb_reg  <= rgb_next;
            hs_pipe  <= {hs_pipe[1:0], hs_s0};
            vs_pipe  <= {vs_pipe[1:0], vs_s0};
        end
    end

    assign {red, green, blue} = rgb_reg;
    assign horizontal_sync    = hs_pipe[2];
    assign vertical_sync      = vs_pipe[2];
endmodule
